// File: rtl/cellrv32_package.sv
// Shared types and constants for the cellrv32 peripheral bus keeper.
// Fault causes and keeper FSM states.
package cellrv32_package;

   typedef enum logic {
      BK_IDLE,
      BK_BUSY
   } bus_keeper_state_t;

   localparam logic [1:0] FAULT_NONE = 2'b00;
   localparam logic [1:0] FAULT_TMO  = 2'b01;
   localparam logic [1:0] FAULT_DEV  = 2'b10;
   localparam logic [1:0] FAULT_COL  = 2'b11;

   // Device-side fault cause; ack together with err is a collision
   function automatic logic [1:0] bk_dev_fault(input logic ack);
      return ack ? FAULT_COL : FAULT_DEV;
   endfunction

endpackage

// File: rtl/cellrv32_bus_keeper.sv
// Peripheral bus watchdog: terminates unanswered accesses with an error
// and records the first faulting access in sticky status registers.
module cellrv32_bus_keeper
   import cellrv32_package::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] bus_addr_i,
   input  logic        bus_src_i,
   input  logic        bus_re_i,
   input  logic        bus_we_i,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   output logic        err_o,
   output logic        busy_o,
   output logic        fault_valid_o,
   output logic [1:0]  fault_type_o,
   output logic [31:0] fault_addr_o,
   output logic        fault_src_o,
   output logic        fault_we_o,
   input  logic        fault_clr_i
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_INIT = CW'(TIMEOUT - 1);

   bus_keeper_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0] acc_addr_q, acc_addr_d;
   logic        acc_src_q, acc_src_d;
   logic        acc_we_q, acc_we_d;

   logic [1:0]  flt_type_q, flt_type_d;
   logic [31:0] flt_addr_q, flt_addr_d;
   logic        flt_src_q, flt_src_d;
   logic        flt_we_q, flt_we_d;

   logic        req, rsp, tmo;
   logic        evt;
   logic [1:0]  evt_type;
   logic [31:0] evt_addr;
   logic        evt_src, evt_we;

   assign req = bus_re_i | bus_we_i;
   assign rsp = bus_ack_i | bus_err_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_addr_d = acc_addr_q;
      acc_src_d  = acc_src_q;
      acc_we_d   = acc_we_q;
      tmo        = 1'b0;
      evt        = 1'b0;
      evt_type   = FAULT_NONE;
      evt_addr   = acc_addr_q;
      evt_src    = acc_src_q;
      evt_we     = acc_we_q;

      unique case (state_q)
         BK_IDLE: begin
            if (req && rsp) begin
               // zero-wait access: fault sees the live bus
               evt      = bus_err_i;
               evt_type = bk_dev_fault(bus_ack_i);
               evt_addr = bus_addr_i;
               evt_src  = bus_src_i;
               evt_we   = bus_we_i;
            end else if (req) begin
               acc_addr_d = bus_addr_i;
               acc_src_d  = bus_src_i;
               acc_we_d   = bus_we_i;
               cnt_d      = CNT_INIT;
               state_d    = BK_BUSY;
            end
         end
         BK_BUSY: begin
            if (rsp) begin
               state_d  = BK_IDLE;
               evt      = bus_err_i;
               evt_type = bk_dev_fault(bus_ack_i);
            end else if (cnt_q == '0) begin
               state_d  = BK_IDLE;
               tmo      = 1'b1;
               evt      = 1'b1;
               evt_type = FAULT_TMO;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_comb begin
      flt_type_d = flt_type_q;
      flt_addr_d = flt_addr_q;
      flt_src_d  = flt_src_q;
      flt_we_d   = flt_we_q;
      // set beats clear; otherwise first fault wins
      if (evt && (!fault_valid_o || fault_clr_i)) begin
         flt_type_d = evt_type;
         flt_addr_d = evt_addr;
         flt_src_d  = evt_src;
         flt_we_d   = evt_we;
      end else if (fault_clr_i) begin
         flt_type_d = FAULT_NONE;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= BK_IDLE;
         cnt_q      <= '0;
         acc_addr_q <= '0;
         acc_src_q  <= 1'b0;
         acc_we_q   <= 1'b0;
         flt_type_q <= FAULT_NONE;
         flt_addr_q <= '0;
         flt_src_q  <= 1'b0;
         flt_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_addr_q <= acc_addr_d;
         acc_src_q  <= acc_src_d;
         acc_we_q   <= acc_we_d;
         flt_type_q <= flt_type_d;
         flt_addr_q <= flt_addr_d;
         flt_src_q  <= flt_src_d;
         flt_we_q   <= flt_we_d;
      end
   end

   assign err_o         = tmo;
   assign busy_o        = (state_q == BK_BUSY);
   assign fault_valid_o = (flt_type_q != FAULT_NONE);
   assign fault_type_o  = flt_type_q;
   assign fault_addr_o  = flt_addr_q;
   assign fault_src_o   = flt_src_q;
   assign fault_we_o    = flt_we_q;

endmodule
